ef_i2s_tx: RTL and testbench

Master-mode I2S transmitter, the playback counterpart of the I2S receiver block. It buffers host-written samples in a FIFO and generates SCK and WS from `clk` with an 8-bit prescaler. Samples are serialized MSB-first on SDO in either standard I2S or left-justified framing, for stereo or single-channel output. It sits between the bus wrapper's FIFO write port and the codec pins.

---
 rtl/ef_i2s_tx_pkg.sv | 22 ++
 rtl/i2s_tx_fifo.sv | 55 +++++
 rtl/ef_i2s_tx.sv | 138 +++++++++++++
 tb/tb_ef_i2s_tx.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ef_i2s_tx_pkg.sv
// Shared I2S definitions: channel encodings, slot width and sample-size clamp.
package ef_i2s_tx_pkg;

  // Channel-enable encodings, shared with the receiver.
  typedef enum logic [1:0] {
    CH_NONE   = 2'b00,
    CH_RIGHT  = 2'b01,
    CH_LEFT   = 2'b10,
    CH_STEREO = 2'b11
  } ch_e;

  localparam int unsigned SLOT_BITS = 32;

  // Sample sizes of 0 or above the slot width mean a full slot.
  function automatic logic [5:0] clamp_size(input logic [5:0] size);
    if (size == 6'd0 || size > 6'(SLOT_BITS)) begin
      return 6'(SLOT_BITS);
    end
    return size;
  endfunction

endpackage

// File: rtl/i2s_tx_fifo.sv
// First-word-fall-through sample FIFO with full/empty flags and occupancy.
module i2s_tx_fifo #(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_wr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_rd,
  output logic [DW-1:0] o_rdata,
  output logic          o_full,
  output logic          o_empty,
  output logic [AW:0]   o_level
);

  localparam logic [AW:0] Depth = {1'b1, {AW{1'b0}}};

  logic [DW-1:0] r_mem [2**AW];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_level;
  logic          w_wr_ok;
  logic          w_rd_ok;

  assign w_wr_ok = i_wr & ~o_full;
  assign w_rd_ok = i_rd & ~o_empty;
  assign o_full  = (r_level == Depth);
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rptr];

  // Storage array; writes while full are dropped.
  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wptr] <= i_wdata;
  end

  // Pointers and occupancy; simultaneous write and pop keep the level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_wr_ok) r_wptr <= r_wptr + 1'b1;
      if (w_rd_ok) r_rptr <= r_rptr + 1'b1;
      unique case ({w_wr_ok, w_rd_ok})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/ef_i2s_tx.sv
// Master-mode I2S transmitter: SCK/WS generation, slot sequencing and MSB-first serializer.
module ef_i2s_tx
  import ef_i2s_tx_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          o_ws,
  output logic          o_sck,
  output logic          o_sdo,
  input  logic          i_fifo_wr,
  input  logic [DW-1:0] i_fifo_wdata,
  input  logic [AW:0]   i_fifo_level_threshold,
  output logic          o_fifo_full,
  output logic          o_fifo_empty,
  output logic [AW:0]   o_fifo_level,
  output logic          o_fifo_level_below,
  output logic          o_underflow,
  input  logic          i_left_justified,
  input  logic [5:0]    i_sample_size,
  input  logic [7:0]    i_sck_prescaler,
  input  logic [1:0]    i_channels,
  input  logic          i_en
);

  logic [7:0]           r_presc;
  logic                 r_sck;
  logic                 r_ws;
  logic [4:0]           r_bit_ctr;
  logic [SLOT_BITS-1:0] r_shift;
  logic                 r_sdo;
  logic                 r_started;
  logic                 r_underflow;

  logic [DW-1:0]        w_head;
  logic [SLOT_BITS-1:0] w_loaded;
  logic [SLOT_BITS-1:0] w_shift_d;
  logic [5:0]           w_size;
  logic                 w_tick;
  logic                 w_fall;
  logic                 w_slot_start;
  logic                 w_left;
  logic                 w_slot_en;
  logic                 w_start_now;
  logic                 w_pop;
  logic                 w_uf;

  i2s_tx_fifo #(
    .DW (DW),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_wr    (i_fifo_wr),
    .i_wdata (i_fifo_wdata),
    .i_rd    (w_pop),
    .o_rdata (w_head),
    .o_full  (o_fifo_full),
    .o_empty (o_fifo_empty),
    .o_level (o_fifo_level)
  );

  assign o_fifo_level_below = (o_fifo_level < i_fifo_level_threshold);

  assign w_tick       = i_en & (r_presc == 8'd0);
  assign w_fall       = w_tick & r_sck;
  assign w_slot_start = w_fall & (r_bit_ctr == 5'd31);

  // Channel of the slot that begins now, judged by the WS level it is about to take.
  assign w_left      = i_left_justified ? ~r_ws : r_ws;
  assign w_slot_en   = w_left ? (i_channels == CH_LEFT  || i_channels == CH_STEREO)
                              : (i_channels == CH_RIGHT || i_channels == CH_STEREO);
  assign w_start_now = r_started | (w_left & ~o_fifo_empty);
  assign w_pop       = w_slot_start & w_start_now & w_slot_en & ~o_fifo_empty;
  assign w_uf        = w_slot_start & w_start_now & w_slot_en & o_fifo_empty;

  // Right-aligned sample moved to the slot MSB, zero pad below.
  assign w_size   = clamp_size(i_sample_size);
  assign w_loaded = w_head[SLOT_BITS-1:0] << (6'(SLOT_BITS) - w_size);

  // Shifter next state: load at slot start, shift left on other falling ticks.
  always_comb begin
    w_shift_d = r_shift;
    if (w_slot_start) begin
      w_shift_d = w_pop ? w_loaded : '0;
    end else if (w_fall) begin
      w_shift_d = {r_shift[SLOT_BITS-2:0], 1'b0};
    end
  end

  // Prescaler, SCK, WS and bit counter; everything holds while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc   <= 8'd0;
      r_sck     <= 1'b0;
      r_ws      <= 1'b1;
      // Start at the last bit so the first falling tick opens a slot.
      r_bit_ctr <= 5'd31;
    end else if (i_en) begin
      r_presc <= (r_presc == 8'd0) ? i_sck_prescaler : r_presc - 8'd1;
      if (w_tick) r_sck <= ~r_sck;
      if (w_slot_start) begin
        r_ws      <= ~r_ws;
        r_bit_ctr <= 5'd0;
      end else if (w_fall) begin
        r_bit_ctr <= r_bit_ctr + 5'd1;
      end
    end
  end

  // Serializer, SDO framing, stream-start flag and underflow pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift     <= '0;
      r_sdo       <= 1'b0;
      r_started   <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_shift <= w_shift_d;
      // I2S takes the pre-shift bit, giving the one-period delay behind WS.
      if (w_fall) r_sdo <= i_left_justified ? w_shift_d[SLOT_BITS-1] : r_shift[SLOT_BITS-1];
      if (!i_en) begin
        r_started <= 1'b0;
      end else if (w_slot_start) begin
        r_started <= w_start_now;
      end
      r_underflow <= w_uf;
    end
  end

  assign o_ws        = r_ws;
  assign o_sck       = r_sck;
  assign o_sdo       = r_sdo;
  assign o_underflow = r_underflow;

endmodule

// File: tb/tb_ef_i2s_tx.sv
// Directed bench for ef_i2s_tx: framing, data, channel masking, FIFO limits and reset.
module tb_ef_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        o_ws, o_sck, o_sdo;
  logic        i_fifo_wr;
  logic [31:0] i_fifo_wdata;
  logic [4:0]  i_fifo_level_threshold;
  logic        o_fifo_full, o_fifo_empty;
  logic [4:0]  o_fifo_level;
  logic        o_fifo_level_below;
  logic        o_underflow;
  logic        i_left_justified;
  logic [5:0]  i_sample_size;
  logic [7:0]  i_sck_prescaler;
  logic [1:0]  i_channels;
  logic        i_en;

  int n_checks = 0;
  int n_pass   = 0;

  ef_i2s_tx #(.DW(32), .AW(4)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .o_ws                   (o_ws),
    .o_sck                  (o_sck),
    .o_sdo                  (o_sdo),
    .i_fifo_wr              (i_fifo_wr),
    .i_fifo_wdata           (i_fifo_wdata),
    .i_fifo_level_threshold (i_fifo_level_threshold),
    .o_fifo_full            (o_fifo_full),
    .o_fifo_empty           (o_fifo_empty),
    .o_fifo_level           (o_fifo_level),
    .o_fifo_level_below     (o_fifo_level_below),
    .o_underflow            (o_underflow),
    .i_left_justified       (i_left_justified),
    .i_sample_size          (i_sample_size),
    .i_sck_prescaler        (i_sck_prescaler),
    .i_channels             (i_channels),
    .i_en                   (i_en)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic timeout_fail(input string tag);
    n_checks++;
    $display("FAIL %s: timeout waiting on DUT", tag);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_en  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [31:0] d);
    @(negedge clk);
    i_fifo_wr    = 1'b1;
    i_fifo_wdata = d;
    @(negedge clk);
    i_fifo_wr    = 1'b0;
  endtask

  // Wait for the next WS change, then capture SDO at each of 32 SCK rises (period 0 -> bit 31).
  task automatic get_slot(output logic [31:0] bits, output logic ws_v, output int uf_cnt);
    logic ws0;
    logic prev_sck;
    int   t;
    int   k;
    bits   = '0;
    uf_cnt = 0;
    ws0    = o_ws;
    ws_v   = ws0;
    t      = 0;
    while (o_ws == ws0 && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (o_ws == ws0) begin
      timeout_fail("slot_ws_edge");
      return;
    end
    ws_v     = o_ws;
    prev_sck = o_sck;
    if (o_underflow) uf_cnt++;
    k = 0;
    t = 0;
    while (k < 32 && t < 3000) begin
      @(negedge clk);
      t++;
      if (o_underflow) uf_cnt++;
      if (o_sck && !prev_sck) begin
        bits[31-k] = o_sdo;
        k++;
      end
      prev_sck = o_sck;
    end
    if (k < 32) timeout_fail("slot_bits");
  endtask

  task automatic slot_check(input string tag, input logic exp_ws, input logic [31:0] exp_bits,
                            input int exp_uf);
    logic [31:0] bits;
    logic        ws_v;
    int          uf;
    get_slot(bits, ws_v, uf);
    check_eq({tag, "_ws"}, 32'(ws_v), 32'(exp_ws));
    check_eq({tag, "_sdo"}, bits, exp_bits);
    check_eq({tag, "_uf"}, uf, exp_uf);
  endtask

  // Clock cycles between two consecutive SCK rises.
  task automatic sck_period(input string tag, input int exp);
    int  t;
    int  n;
    logic prev;
    prev = o_sck;
    t = 0;
    n = -1;
    while (t < 100) begin
      @(negedge clk);
      t++;
      if (o_sck && !prev) begin
        if (n >= 0) break;
        n = 0;
      end else if (n >= 0) begin
        n++;
      end
      prev = o_sck;
    end
    if (t >= 100) timeout_fail(tag);
    else check_eq(tag, n + 1, exp);
  endtask

  task automatic reset_outputs(input string tag);
    check_eq({tag, "_sck"},   32'(o_sck), 0);
    check_eq({tag, "_ws"},    32'(o_ws), 1);
    check_eq({tag, "_sdo"},   32'(o_sdo), 0);
    check_eq({tag, "_empty"}, 32'(o_fifo_empty), 1);
    check_eq({tag, "_full"},  32'(o_fifo_full), 0);
    check_eq({tag, "_level"}, 32'(o_fifo_level), 0);
    check_eq({tag, "_uf"},    32'(o_underflow), 0);
  endtask

  initial begin
    int   t;
    logic [4:0] prev_level;
    logic prev_below;
    logic seen;

    rst_n = 1'b0;
    i_en = 1'b0;
    i_fifo_wr = 1'b0;
    i_fifo_wdata = '0;
    i_fifo_level_threshold = 5'd0;
    i_left_justified = 1'b0;
    i_sample_size = 6'd32;
    i_sck_prescaler = 8'd0;
    i_channels = 2'b11;
    repeat (3) @(negedge clk);
    reset_outputs("rst");
    rst_n = 1'b1;

    // Left-justified stereo, 32-bit samples
    apply_reset();
    i_left_justified = 1'b1;
    i_sample_size = 6'd32;
    i_sck_prescaler = 8'd0;
    i_channels = 2'b11;
    push(32'hA5A50001);
    push(32'h80000000);
    check_eq("lj_level2", 32'(o_fifo_level), 2);
    i_en = 1'b1;
    slot_check("lj_s0_pre", 1'b0, 32'h0, 0);
    slot_check("lj_s1_left", 1'b1, 32'hA5A50001, 0);
    check_eq("lj_level1", 32'(o_fifo_level), 1);
    slot_check("lj_s2_right", 1'b0, 32'h80000000, 0);
    check_eq("lj_empty", 32'(o_fifo_empty), 1);
    slot_check("lj_s3_uf", 1'b1, 32'h0, 1);
    slot_check("lj_s4_uf", 1'b0, 32'h0, 1);
    sck_period("lj_period", 2);

    // I2S framing, 16-bit samples, prescaler 1
    apply_reset();
    i_left_justified = 1'b0;
    i_sample_size = 6'd16;
    i_sck_prescaler = 8'd1;
    i_channels = 2'b11;
    push(32'h00008001);
    push(32'h0000FFFF);
    i_en = 1'b1;
    slot_check("i2s_left", 1'b0, 32'h40008000, 0);
    slot_check("i2s_right", 1'b1, 32'h7FFF8000, 0);
    slot_check("i2s_uf", 1'b0, 32'h0, 1);
    sck_period("i2s_period", 4);

    // Mono left, I2S, sample_size 0 treated as a full slot
    apply_reset();
    i_left_justified = 1'b0;
    i_sample_size = 6'd0;
    i_sck_prescaler = 8'd0;
    i_channels = 2'b10;
    push(32'h12345678);
    push(32'hCAFEF00E);
    push(32'h0F0F0F0E);
    check_eq("mono_level3", 32'(o_fifo_level), 3);
    i_en = 1'b1;
    slot_check("mono_l1", 1'b0, 32'h091A2B3C, 0);
    check_eq("mono_level2", 32'(o_fifo_level), 2);
    slot_check("mono_r1", 1'b1, 32'h0, 0);
    slot_check("mono_l2", 1'b0, 32'h657F7807, 0);
    check_eq("mono_level1", 32'(o_fifo_level), 1);
    slot_check("mono_r2", 1'b1, 32'h0, 0);
    slot_check("mono_l3", 1'b0, 32'h07878787, 0);
    check_eq("mono_level0", 32'(o_fifo_level), 0);
    slot_check("mono_r3", 1'b1, 32'h0, 0);
    slot_check("mono_l4_uf", 1'b0, 32'h0, 1);

    // FIFO full, dropped 17th write, threshold crossing, then reset mid-frame
    apply_reset();
    i_fifo_level_threshold = 5'd4;
    i_left_justified = 1'b1;
    i_sample_size = 6'd32;
    i_sck_prescaler = 8'd0;
    i_channels = 2'b11;
    for (int k = 0; k < 17; k++) push(32'h100 + 32'(k));
    check_eq("full_level16", 32'(o_fifo_level), 16);
    check_eq("full_flag", 32'(o_fifo_full), 1);
    check_eq("full_below", 32'(o_fifo_level_below), 0);
    i_en = 1'b1;
    prev_level = o_fifo_level;
    prev_below = o_fifo_level_below;
    seen = 1'b0;
    t = 0;
    while (!seen && t < 4000) begin
      @(negedge clk);
      t++;
      if (o_fifo_level == 5'd3 && prev_level == 5'd4) begin
        seen = 1'b1;
        check_eq("thr_below_at4", 32'(prev_below), 0);
        check_eq("thr_below_at3", 32'(o_fifo_level_below), 1);
      end
      prev_level = o_fifo_level;
      prev_below = o_fifo_level_below;
    end
    if (!seen) timeout_fail("thr_cross");
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    reset_outputs("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check_eq("midrst_discard", 32'(o_fifo_level), 0);
    i_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
